// File: rtl/timer_scheduler_pkg.sv
// rtl/timer_scheduler_pkg.sv - shared state encoding and client indices for the timer scheduler
package timer_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEL       = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_LOW  = 3'd3,
      ST_WAIT_HIGH = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

   localparam int CL_MAIN  = 0;
   localparam int CL_ARM   = 1;
   localparam int CL_PASS  = 2;
   localparam int CL_SIREN = 3;

   // States in which the owner holds a live run that can be preempted, retriggered or cancelled
   function automatic logic is_running(input state_e s);
      return (s == ST_SEL) || (s == ST_START) || (s == ST_WAIT_LOW) || (s == ST_WAIT_HIGH);
   endfunction

endpackage

// File: rtl/timer_scheduler_prio_pick.sv
// rtl/timer_scheduler_prio_pick.sv - fixed-priority picker, lowest index wins
module timer_scheduler_prio_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      onehot = '0;
      index  = '0;
      valid  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            index     = IDX_W'(i);
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - arbitrates the shared countdown timer among the alarm sub-FSMs
module timer_scheduler
   import timer_scheduler_pkg::*;
#(
   parameter int N_CLIENTS = 4,
   parameter int IW        = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_CLIENTS-1:0]    req,
   input  logic [N_CLIENTS*IW-1:0] req_interval,
   input  logic [N_CLIENTS-1:0]    cancel,
   input  logic                    expired,
   output logic [IW-1:0]           interval_sel,
   output logic                    start_timer,
   output logic                    busy,
   output logic [N_CLIENTS-1:0]    owner,
   output logic [N_CLIENTS-1:0]    done,
   output logic [N_CLIENTS-1:0]    aborted
);

   localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

   state_e                        state_q, state_d;
   logic [N_CLIENTS-1:0]          pending_q, pending_d;
   logic [N_CLIENTS-1:0][IW-1:0]  int_q, int_d;
   logic [N_CLIENTS-1:0]          owner_q, owner_d;
   logic [IW-1:0]                 isel_q, isel_d;

   logic [N_CLIENTS-1:0]          consume;
   logic [N_CLIENTS-1:0]          gnt_oh, pre_oh;
   logic [IDX_W-1:0]              gnt_idx, pre_idx;
   logic                          gnt_vld, pre_vld;
   logic [IW-1:0]                 owner_req_int;
   logic                          running, owner_cancel, owner_retrig, preempt;

   // Grant candidate among all pending clients
   timer_scheduler_prio_pick #(.N(N_CLIENTS), .IDX_W(IDX_W)) u_grant_pick (
      .req    (pending_q),
      .onehot (gnt_oh),
      .index  (gnt_idx),
      .valid  (gnt_vld)
   );

   // Preemption candidate: only pending clients strictly above the owner in priority
   timer_scheduler_prio_pick #(.N(N_CLIENTS), .IDX_W(IDX_W)) u_preempt_pick (
      .req    (pending_q & (owner_q - N_CLIENTS'(1))),
      .onehot (pre_oh),
      .index  (pre_idx),
      .valid  (pre_vld)
   );

   // Qualify the busy-state events and select the owner's fresh interval for a retrigger
   always_comb begin
      running       = is_running(state_q);
      owner_cancel  = running && |(cancel & owner_q);
      owner_retrig  = running && |(req & owner_q);
      preempt       = running && pre_vld && !owner_cancel;
      owner_req_int = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         int_d[i] = req[i] ? req_interval[i*IW +: IW] : int_q[i];
         if (owner_q[i]) begin
            owner_req_int = owner_req_int | req_interval[i*IW +: IW];
         end
      end
   end

   // Next state, ownership and interval select; priority is cancel > preempt > retrigger > expiry
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      isel_d  = isel_q;
      consume = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               owner_d = gnt_oh;
               isel_d  = int_q[gnt_idx];
               consume = gnt_oh;
               state_d = ST_SEL;
            end
         end
         ST_SEL, ST_START, ST_WAIT_LOW, ST_WAIT_HIGH: begin
            if (owner_cancel) begin
               owner_d = '0;
               state_d = ST_IDLE;
            end else if (preempt) begin
               owner_d = pre_oh;
               isel_d  = int_q[pre_idx];
               consume = pre_oh;
               state_d = ST_SEL;
            end else if (owner_retrig) begin
               isel_d  = owner_req_int;
               consume = owner_q;
               state_d = ST_SEL;
            end else begin
               case (state_q)
                  ST_SEL:      state_d = ST_START;
                  ST_START:    state_d = ST_WAIT_LOW;
                  ST_WAIT_LOW: state_d = expired ? ST_WAIT_LOW : ST_WAIT_HIGH;
                  default:     state_d = expired ? ST_DONE : ST_WAIT_HIGH;
               endcase
            end
         end
         ST_DONE: begin
            owner_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            owner_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      pending_d = (pending_q | req) & ~cancel & ~consume;
   end

   // Moore outputs from state, plus the abort pulse raised in the cycle the preemption is decided
   always_comb begin
      start_timer = (state_q == ST_START);
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE) ? owner_q : '0;
      aborted     = preempt ? owner_q : '0;
   end

   assign owner        = owner_q;
   assign interval_sel = isel_q;

   // State and datapath registers; reset drops any owner without a done or aborted pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         int_q     <= '0;
         owner_q   <= '0;
         isel_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         int_q     <= int_d;
         owner_q   <= owner_d;
         isel_q    <= isel_d;
      end
   end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Shares the single countdown timer and its interval-select input of the time-parameter table among several alarm sub-FSMs (main alarm FSM, arming FSM, passenger-door delay, siren stop).
- Latches start requests, grants the timer to one client by fixed priority and drives the interval select.
- Issues a single start pulse and qualifies `expired` with a low-then-high handshake.
- Returns per-client done/aborted pulses. Sits in top between the control FSMs and the timer/time_parameters drivers.

Parameters:
- N_CLIENTS, 4, number of requesters; index 0 has highest priority.
- IW, 2, interval-select width; matches the time-parameter table index.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_CLIENTS  one-cycle start-request pulses, one bit per client
- req_interval  in  N_CLIENTS*IW  interval index per client; client i uses bits [i*IW +: IW]
- cancel  in  N_CLIENTS  one-cycle cancel pulses
- expired  in  1  timer expired flag (level)
- interval_sel  out  IW  interval index to time_parameters
- start_timer  out  1  one-cycle timer load/start pulse
- busy  out  1  high when the timer is owned (states SEL..DONE)
- owner  out  N_CLIENTS  one-hot current owner; zero when idle
- done  out  N_CLIENTS  one-cycle pulse to the owner on normal expiry
- aborted  out  N_CLIENTS  one-cycle pulse to an owner that was preempted

Behaviour:
- Reset values: all outputs 0. State = IDLE. Pending and latched interval registers cleared. Reset mid-operation abandons the owner silently, with no done or aborted pulse.
- pending[i] is set on req[i] and cleared on cancel[i] or when client i is granted. If req[i] and cancel[i] arrive in the same cycle, cancel wins. On a request, the client's req_interval is latched into int_q[i].
- States:
  - IDLE: if any pending bit is set, grant the lowest index: owner <= onehot(i), interval_sel <= int_q[i], pending[i] cleared, go to SEL.
  - SEL: one settle cycle so that time_parameters' registered value follows interval_sel. Go to START.
  - START: start_timer = 1 for exactly this cycle. Go to WAIT_LOW.
  - WAIT_LOW: wait until expired == 0. Go to WAIT_HIGH. This guards against a stale expired from the previous run.
  - WAIT_HIGH: when expired == 1, go to DONE.
  - DONE: done[owner] = 1 for one cycle. Clear owner. Go to IDLE.
- Preemption applies in SEL..WAIT_HIGH. If a client j with j < owner index has a pending request, pulse aborted[owner], grant j and go to SEL in the next cycle.
- Retrigger: a req from the current owner while in SEL..WAIT_HIGH restarts the run. Return to SEL with the new interval; no aborted pulse.
- Owner cancel: in SEL..WAIT_HIGH, the owner returns to IDLE next cycle with no done pulse. A cancel from a non-owner clears only its pending bit.
- Same-cycle priority in a busy state: owner cancel > higher-priority preemption > owner retrigger > expiry.
- Latency from an idle req to start_timer: 3 cycles (req latched, IDLE grant, SEL, START).
- Back-to-back: a request pending at DONE is granted in the IDLE cycle that follows; there are no fairness counters.
- interval_sel holds its value from grant until the next grant; it does not return to 0 when idle.

Decomposition:
- Shared package holds the state encoding (IDLE, SEL, START, WAIT_LOW, WAIT_HIGH, DONE, 3 bits) and client index constants (CL_MAIN=0, CL_ARM=1, CL_PASS=2, CL_SIREN=3).
- One sub-module, prio_pick: N-bit fixed-priority one-hot encoder plus index output. It is used both for the grant and for the preemption check, masked below the owner index.

Test Plan:
1. Reset, then req[2] with interval 2: owner=4'b0100 and interval_sel=2 after 1 cycle; start_timer high exactly at cycle 3. Model expired 1→0→1, then done[2] pulses once and busy falls.
2. Stale expired: expired held at 1 before START → no done until expired has gone 0 and then back to 1.
3. Preemption: client 3 running in WAIT_HIGH, req[0] interval 0 → aborted[3] pulse, owner=4'b0001, interval_sel=0, new start_timer 2 cycles later.
4. Simultaneous req[1] and req[3] in IDLE → client 1 granted. Client 3 stays pending and gets the timer (start_timer pulse) after done[1].
5. Owner cancel during WAIT_HIGH plus expired in the same cycle → IDLE, no done, no aborted. A same-cycle req+cancel on an idle client leaves pending clear.
6. Async reset asserted mid-WAIT_HIGH → all outputs 0 immediately. After release with no requests, state stays IDLE.
